// File: rtl/reg_file_pkg.sv
// Shared register-file constants and address/data types for the datapath,
// decoder and controller.
package reg_file_pkg;

   localparam int DW_DEF = 8;
   localparam int PW_DEF = 3;

   typedef logic [PW_DEF-1:0] reg_addr_t;
   typedef logic [DW_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: load issue sets busy, load return clears it,
// and a mark of a still-busy register raises a one-cycle sb_err pulse.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int PW      = PW_DEF,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mark_en,
   input  logic [PW-1:0]    mark_addr,
   input  logic             clr_en,
   input  logic [PW-1:0]    clr_addr,
   output logic [2**PW-1:0] busy_vec,
   output logic             sb_err
);

   localparam int NREG = 2**PW;

   logic [NREG-1:0] busy_nxt;
   logic            err_nxt;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      busy_nxt = busy_vec;
      for (int i = 0; i < NREG; i++) begin
         // A mark outranks a same-cycle clear: the new load is still outstanding.
         if (mark_en && mark_addr == PW'(i))
            busy_nxt[i] = 1'b1;
         else if (clr_en && clr_addr == PW'(i))
            busy_nxt[i] = 1'b0;
      end
      if (ZERO_R0)
         busy_nxt[0] = 1'b0;
      err_nxt = mark_en && busy_vec[mark_addr]
                && !(clr_en && clr_addr == mark_addr)
                && !(ZERO_R0 && mark_addr == '0);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_vec <= '0;
         sb_err   <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;
         sb_err   <= err_nxt;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: two combinational read ports, ALU and load-return
// write ports (load return wins a collision), optional bypass and zero register.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int PW      = PW_DEF,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wrA_en,
   input  logic [PW-1:0]    wrA_addr,
   input  logic [DW-1:0]    wrA_dat,
   input  logic             wrB_en,
   input  logic [PW-1:0]    wrB_addr,
   input  logic [DW-1:0]    wrB_dat,
   input  logic             mark_en,
   input  logic [PW-1:0]    mark_addr,
   input  logic [PW-1:0]    rd_addrA,
   input  logic [PW-1:0]    rd_addrB,
   output logic [DW-1:0]    datA_out,
   output logic [DW-1:0]    datB_out,
   output logic             busyA,
   output logic             busyB,
   output logic [2**PW-1:0] busy_vec,
   output logic             sb_err
);

   localparam int NREG = 2**PW;

   logic [DW-1:0] core [NREG];
   logic [PW-1:0] rd_addr [2];
   logic [DW-1:0] rd_dat  [2];
   logic          rd_busy [2];

   reg_scoreboard #(.PW(PW), .ZERO_R0(ZERO_R0)) u_sb (
      .clk       (clk),
      .reset     (reset),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .clr_en    (wrB_en),
      .clr_addr  (wrB_addr),
      .busy_vec  (busy_vec),
      .sb_err    (sb_err)
   );

   // NOTE: the array is reset because a cleared register file is architectural state here, which keeps it out of RAM macros.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            core[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (!(ZERO_R0 && i == 0)) begin
               if (wrB_en && wrB_addr == PW'(i))
                  core[i] <= wrB_dat;
               else if (wrA_en && wrA_addr == PW'(i))
                  core[i] <= wrA_dat;
            end
         end
      end
   end

   assign rd_addr[0] = rd_addrA;
   assign rd_addr[1] = rd_addrB;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_dat[p]  = core[rd_addr[p]];
         rd_busy[p] = busy_vec[rd_addr[p]];
         if (BYPASS) begin
            if (wrB_en && wrB_addr == rd_addr[p]) begin
               rd_dat[p] = wrB_dat;
               if (!(mark_en && mark_addr == rd_addr[p]))
                  rd_busy[p] = 1'b0;
            end else if (wrA_en && wrA_addr == rd_addr[p]) begin
               rd_dat[p] = wrA_dat;
            end
         end
         // Reset also masks bypassed write data so outputs read 0 while it is held.
         if (reset || (ZERO_R0 && rd_addr[p] == '0)) begin
            rd_dat[p]  = '0;
            rd_busy[p] = 1'b0;
         end
      end
   end

   assign datA_out = rd_dat[0];
   assign datB_out = rd_dat[1];
   assign busyA    = rd_busy[0];
   assign busyB    = rd_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: three builds (default, zero register,
// no bypass) share stimulus and are compared against an array-based model.
module tb_reg_file_sb;

   localparam int NI = 3;

   logic       clk, reset;
   logic       wrA_en, wrB_en, mark_en;
   logic [2:0] wrA_addr, wrB_addr, mark_addr, rd_addrA, rd_addrB;
   logic [7:0] wrA_dat, wrB_dat;

   logic [7:0] dat_a [NI];
   logic [7:0] dat_b [NI];
   logic       busy_a [NI];
   logic       busy_b [NI];
   logic [7:0] bvec [NI];
   logic       err [NI];

   string inst_name [NI] = '{"dflt", "zero", "nobyp"};

   int n_checks = 0;
   int n_err    = 0;

   // Model state: index 0 = ZERO_R0=0 builds, index 1 = ZERO_R0=1 build.
   logic [7:0] m_core [2][8];
   logic       m_busy [2][8];
   logic       m_err  [2];

   reg_file_sb #(.DW(8), .PW(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut (
      .clk(clk), .reset(reset),
      .wrA_en(wrA_en), .wrA_addr(wrA_addr), .wrA_dat(wrA_dat),
      .wrB_en(wrB_en), .wrB_addr(wrB_addr), .wrB_dat(wrB_dat),
      .mark_en(mark_en), .mark_addr(mark_addr),
      .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
      .datA_out(dat_a[0]), .datB_out(dat_b[0]), .busyA(busy_a[0]), .busyB(busy_b[0]),
      .busy_vec(bvec[0]), .sb_err(err[0])
   );

   reg_file_sb #(.DW(8), .PW(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_zero (
      .clk(clk), .reset(reset),
      .wrA_en(wrA_en), .wrA_addr(wrA_addr), .wrA_dat(wrA_dat),
      .wrB_en(wrB_en), .wrB_addr(wrB_addr), .wrB_dat(wrB_dat),
      .mark_en(mark_en), .mark_addr(mark_addr),
      .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
      .datA_out(dat_a[1]), .datB_out(dat_b[1]), .busyA(busy_a[1]), .busyB(busy_b[1]),
      .busy_vec(bvec[1]), .sb_err(err[1])
   );

   reg_file_sb #(.DW(8), .PW(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_nb (
      .clk(clk), .reset(reset),
      .wrA_en(wrA_en), .wrA_addr(wrA_addr), .wrA_dat(wrA_dat),
      .wrB_en(wrB_en), .wrB_addr(wrB_addr), .wrB_dat(wrB_dat),
      .mark_en(mark_en), .mark_addr(mark_addr),
      .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
      .datA_out(dat_a[2]), .datB_out(dat_b[2]), .busyA(busy_a[2]), .busyB(busy_b[2]),
      .busy_vec(bvec[2]), .sb_err(err[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int m = 0; m < 2; m++) begin
         for (int r = 0; r < 8; r++) begin
            m_core[m][r] = 8'h00;
            m_busy[m][r] = 1'b0;
         end
         m_err[m] = 1'b0;
      end
   endtask

   // Applies one rising edge with the current inputs; later statements override earlier ones.
   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         bit z;
         logic e;
         z = (m == 1);
         e = mark_en && m_busy[m][mark_addr] && !(wrB_en && wrB_addr == mark_addr)
             && !(z && mark_addr == 3'd0);
         if (wrA_en && !(z && wrA_addr == 3'd0)) m_core[m][wrA_addr] = wrA_dat;
         if (wrB_en && !(z && wrB_addr == 3'd0)) m_core[m][wrB_addr] = wrB_dat;
         if (wrB_en) m_busy[m][wrB_addr] = 1'b0;
         if (mark_en && !(z && mark_addr == 3'd0)) m_busy[m][mark_addr] = 1'b1;
         m_err[m] = e;
      end
   endtask

   function automatic logic [7:0] exp_dat(int k, logic [2:0] a);
      int m;
      m = (k == 1) ? 1 : 0;
      if (reset) return 8'h00;
      if (k == 1 && a == 3'd0) return 8'h00;
      if (k != 2) begin
         if (wrB_en && wrB_addr == a) return wrB_dat;
         if (wrA_en && wrA_addr == a) return wrA_dat;
      end
      return m_core[m][a];
   endfunction

   function automatic logic exp_busy(int k, logic [2:0] a);
      int m;
      m = (k == 1) ? 1 : 0;
      if (reset) return 1'b0;
      if (k == 1 && a == 3'd0) return 1'b0;
      if (k != 2 && wrB_en && wrB_addr == a && !(mark_en && mark_addr == a)) return 1'b0;
      return m_busy[m][a];
   endfunction

   function automatic logic [7:0] exp_vec(int k);
      logic [7:0] v;
      int m;
      m = (k == 1) ? 1 : 0;
      for (int r = 0; r < 8; r++) v[r] = m_busy[m][r];
      return v;
   endfunction

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         check({inst_name[k], ".datA"}, 32'(dat_a[k]), 32'(exp_dat(k, rd_addrA)));
         check({inst_name[k], ".datB"}, 32'(dat_b[k]), 32'(exp_dat(k, rd_addrB)));
         check({inst_name[k], ".busyA"}, 32'(busy_a[k]), 32'(exp_busy(k, rd_addrA)));
         check({inst_name[k], ".busyB"}, 32'(busy_b[k]), 32'(exp_busy(k, rd_addrB)));
         check({inst_name[k], ".busy_vec"}, 32'(bvec[k]), 32'(exp_vec(k)));
         check({inst_name[k], ".sb_err"}, 32'(err[k]), 32'(m_err[(k == 1) ? 1 : 0]));
      end
   endtask

   // Called at a falling edge once inputs are applied.
   task automatic settle();
      if (reset) model_clear();
      #1;
      check_all();
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      wrA_en = 1'b0; wrA_addr = 3'd0; wrA_dat = 8'h00;
      wrB_en = 1'b0; wrB_addr = 3'd0; wrB_dat = 8'h00;
      mark_en = 1'b0; mark_addr = 3'd0;
   endtask

   typedef struct {
      logic       wa_en; logic [2:0] wa_ad; logic [7:0] wa_d;
      logic       wb_en; logic [2:0] wb_ad; logic [7:0] wb_d;
      logic       mk_en; logic [2:0] mk_ad;
      logic [2:0] ra;    logic [2:0] rb;
      logic [7:0] e_da;  logic [7:0] e_db;
      logic       e_ba;  logic       e_err;
   } vec_t;

   vec_t tbl [13];

   initial begin
      // Expected values are for the default build, starting from reset.
      tbl[0]  = '{1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 3'd0, 3'd2, 3'd2, 8'h22, 8'h22, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd2, 8'h22, 8'h22, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd5, 3'd2, 8'h00, 8'h22, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd2, 8'h00, 8'h22, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd2, 8'h00, 8'h22, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h7E, 1'b0, 3'd0, 3'd5, 3'd2, 8'h7E, 8'h22, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd2, 8'h7E, 8'h22, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6, 3'd2, 8'h00, 8'h22, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h44, 1'b1, 3'd6, 3'd6, 3'd2, 8'h44, 8'h22, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd2, 8'h44, 8'h22, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6, 3'd2, 8'h44, 8'h22, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd2, 8'h44, 8'h22, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd2, 8'h44, 8'h22, 1'b1, 1'b0};

      reset = 1'b1;
      idle();
      rd_addrA = 3'd0;
      rd_addrB = 3'd0;
      @(negedge clk);
      settle();
      edge_step();
      reset = 1'b0;

      // Table: collision, load lifecycle, mark/clear race and sb_err pulse.
      for (int i = 0; i < 13; i++) begin
         wrA_en = tbl[i].wa_en; wrA_addr = tbl[i].wa_ad; wrA_dat = tbl[i].wa_d;
         wrB_en = tbl[i].wb_en; wrB_addr = tbl[i].wb_ad; wrB_dat = tbl[i].wb_d;
         mark_en = tbl[i].mk_en; mark_addr = tbl[i].mk_ad;
         rd_addrA = tbl[i].ra; rd_addrB = tbl[i].rb;
         settle();
         check($sformatf("tbl%0d.datA", i), 32'(dat_a[0]), 32'(tbl[i].e_da));
         check($sformatf("tbl%0d.datB", i), 32'(dat_b[0]), 32'(tbl[i].e_db));
         check($sformatf("tbl%0d.busyA", i), 32'(busy_a[0]), 32'(tbl[i].e_ba));
         check($sformatf("tbl%0d.sb_err", i), 32'(err[0]), 32'(tbl[i].e_err));
         edge_step();
      end
      check("lifecycle.busy_vec5", 32'(bvec[0][5]), 32'd0);
      check("race.busy_vec6", 32'(bvec[0][6]), 32'd1);

      // Asynchronous reset between edges, with a write pending.
      idle(); wrA_en = 1'b1; wrA_addr = 3'd3; wrA_dat = 8'h5A;
      settle(); edge_step();
      idle(); mark_en = 1'b1; mark_addr = 3'd4;
      settle(); edge_step();
      idle(); rd_addrA = 3'd3;
      settle();
      check("rst.pre_datA", 32'(dat_a[0]), 32'h5A);
      #2;
      reset = 1'b1;
      wrA_en = 1'b1; wrA_addr = 3'd3; wrA_dat = 8'h77;
      settle();
      check("rst.held_datA", 32'(dat_a[0]), 32'h00);
      check("rst.held_busy_vec", 32'(bvec[0]), 32'h00);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle();
      settle();
      check("rst.after_datA", 32'(dat_a[0]), 32'h00);
      edge_step();

      // Zero register ignores writes and marks.
      idle(); wrA_en = 1'b1; wrA_addr = 3'd0; wrA_dat = 8'hFF;
      mark_en = 1'b1; mark_addr = 3'd0; rd_addrA = 3'd0;
      settle(); edge_step();
      idle(); mark_en = 1'b1; mark_addr = 3'd0;
      settle();
      check("zero.datA", 32'(dat_a[1]), 32'h00);
      check("zero.busyA", 32'(busy_a[1]), 32'd0);
      edge_step();
      idle();
      settle();
      check("zero.sb_err", 32'(err[1]), 32'd0);
      check("zero.dflt_sb_err", 32'(err[0]), 32'd1);
      edge_step();

      // No-bypass build shows the stored value until the edge.
      idle(); wrA_en = 1'b1; wrA_addr = 3'd1; wrA_dat = 8'h10; rd_addrA = 3'd1;
      settle(); edge_step();
      wrA_dat = 8'h33;
      settle();
      check("nobyp.old_datA", 32'(dat_a[2]), 32'h10);
      check("byp.new_datA", 32'(dat_a[0]), 32'h33);
      edge_step();
      idle();
      settle();
      check("nobyp.next_datA", 32'(dat_a[2]), 32'h33);
      edge_step();

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         reset    = ($urandom_range(0, 63) == 0);
         wrA_en   = ($urandom_range(0, 1) == 1);
         wrA_addr = 3'($urandom_range(0, 7));
         wrA_dat  = 8'($urandom);
         wrB_en   = ($urandom_range(0, 2) == 0);
         wrB_addr = ($urandom_range(0, 3) == 0) ? wrA_addr : 3'($urandom_range(0, 7));
         wrB_dat  = 8'($urandom);
         mark_en  = ($urandom_range(0, 2) == 0);
         mark_addr = ($urandom_range(0, 3) == 0) ? wrB_addr : 3'($urandom_range(0, 7));
         rd_addrA = ($urandom_range(0, 2) == 0) ? wrB_addr : 3'($urandom_range(0, 7));
         rd_addrB = ($urandom_range(0, 2) == 0) ? wrA_addr : 3'($urandom_range(0, 7));
         settle();
         edge_step();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
